// File: rtl/apb_req_arbiter.sv
// Two-requester round-robin front end for a single APB master bridge.
// Holds one command on the bridge inputs, returns read data or error to the owner.
module apb_req_arbiter #(
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic [1:0]            req_valid,
    input  logic [1:0]            req_write,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic [1:0]            req_ready,
    output logic [1:0]            rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  transfer,
    output logic                  READ_WRITE,
    output logic [ADDR_W-1:0]     apb_write_paddr,
    output logic [ADDR_W-1:0]     apb_read_paddr,
    output logic [DATA_W-1:0]     apb_write_data,
    input  logic                  PENABLE,
    input  logic                  PREADY,
    input  logic                  PSLVERR,
    input  logic [DATA_W-1:0]     apb_read_data_out,
    output logic                  busy,
    output logic [7:0]            err_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q;
    logic                last_grant_q;
    logic                owner_q;
    logic [7:0]          wait_q;
    logic                transfer_q;
    logic                read_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [1:0]          rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                rsp_err_q;
    logic                busy_q;
    logic [7:0]          err_count_q;

    logic [1:0]          grant;
    logic                sel_d;
    logic                write_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   wdata_d;
    logic [7:0]          err_count_d;
    logic                done_ok;
    logic                done_err;

    // When both request, the one that did not win last time gets the bridge.
    always_comb begin
        grant = '0;
        if (state_q == IDLE) begin
            if (req_valid == 2'b11)
                grant = last_grant_q ? 2'b01 : 2'b10;
            else
                grant = req_valid;
        end
    end

    always_comb begin
        sel_d   = grant[1];
        write_d = req_write[sel_d];
        addr_d  = req_addr[sel_d*ADDR_W +: ADDR_W];
        wdata_d = req_wdata[sel_d*DATA_W +: DATA_W];
    end

    always_comb begin
        err_count_d = err_count_q;
        if (rsp_err_q && (err_count_q != 8'hFF))
            err_count_d = err_count_q + 8'd1;
    end

    assign done_err = PSLVERR || (!(PENABLE && PREADY) && (wait_q == 8'(TIMEOUT - 1)));
    assign done_ok  = !PSLVERR && PENABLE && PREADY;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            wait_q       <= '0;
            transfer_q   <= 1'b0;
            read_q       <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
            err_count_q  <= '0;
        end else begin
            rsp_valid_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (|grant) begin
                        read_q       <= ~write_d;
                        addr_q       <= addr_d;
                        wdata_q      <= wdata_d;
                        owner_q      <= sel_d;
                        last_grant_q <= sel_d;
                        wait_q       <= '0;
                        transfer_q   <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= XFER;
                    end
                end
                XFER: begin
                    wait_q <= wait_q + 8'd1;
                    if (done_ok || done_err) begin
                        transfer_q           <= 1'b0;
                        rsp_valid_q[owner_q] <= 1'b1;
                        rsp_err_q            <= done_err;
                        rsp_rdata_q          <= (done_ok && read_q) ? apb_read_data_out : '0;
                        state_q              <= RESP;
                    end
                end
                RESP: begin
                    err_count_q <= err_count_d;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= '0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready       = grant;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_rdata       = rsp_rdata_q;
    assign rsp_err         = rsp_err_q;
    assign transfer        = transfer_q;
    assign READ_WRITE      = read_q;
    assign apb_write_paddr = addr_q;
    assign apb_read_paddr  = addr_q;
    assign apb_write_data  = wdata_q;
    assign busy            = busy_q;
    assign err_count       = err_count_q;

endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
- Shares the single APB master bridge between two independent command requesters (e.g. a config sequencer and a test/debug port).
- Arbitrates round-robin, holds one command on the bridge's transfer/READ_WRITE/address/data inputs, and detects completion from PENABLE/PREADY.
- Returns read data or an error to the owning requester, with a wait-state timeout.
- Sits directly upstream of the bridge.

Parameters:
- ADDR_W, 9, address width; matches bridge apb_write_paddr/apb_read_paddr.
- DATA_W, 8, data width; matches bridge apb_write_data/apb_read_data_out.
- TIMEOUT, 32, maximum XFER cycles before abort (valid range 4..255).

Ports:
- PCLK  in  1  clock; all state changes on rising edge.
- PRESET  in  1  reset, asynchronous, active-high.
- req_valid  in  2  per-requester command valid; bit i = requester i.
- req_write  in  2  per-requester direction; 1 = write, 0 = read.
- req_addr  in  2*ADDR_W  per-requester address; requester i in slice [i*ADDR_W +: ADDR_W].
- req_wdata  in  2*DATA_W  per-requester write data, same packing.
- req_ready  out  2  command accepted; acceptance = req_valid[i] & req_ready[i] at an edge.
- rsp_valid  out  2  one-cycle response pulse to the owner.
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid; 0 for writes and errors.
- rsp_err  out  1  error flag, valid with rsp_valid.
- transfer  out  1  to bridge transfer.
- READ_WRITE  out  1  to bridge; 1 = read.
- apb_write_paddr  out  ADDR_W  to bridge.
- apb_read_paddr  out  ADDR_W  to bridge.
- apb_write_data  out  DATA_W  to bridge.
- PENABLE  in  1  from bridge.
- PREADY  in  1  APB slave ready, shared with bridge.
- PSLVERR  in  1  from bridge.
- apb_read_data_out  in  DATA_W  from bridge.
- busy  out  1  high in XFER or RESP.
- err_count  out  8  saturating count of error responses.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - state = IDLE; all registered outputs = 0; err_count = 0; last_grant = 1.
  - No rsp_valid is issued for an aborted command.
- FSM states: IDLE, XFER, RESP.
- IDLE:
  - transfer = 0.
  - req_ready is combinational: grant one-hot among asserted req_valid.
  - When both are valid, the requester != last_grant wins.
  - On acceptance edge: latch write/addr/wdata into hold registers, record owner, set last_grant = owner, clear wait counter, go to XFER.
- XFER:
  - transfer = 1; READ_WRITE = ~hold_write.
  - apb_write_paddr and apb_read_paddr both = hold_addr; apb_write_data = hold_wdata. All held stable.
  - req_ready = 0.
  - Wait counter increments each cycle.
  - Priority at each edge:
    - PSLVERR = 1 -> err, go to RESP.
    - PENABLE & PREADY -> ok; capture apb_read_data_out if read; go to RESP.
    - counter == TIMEOUT-1 -> err, go to RESP.
- RESP:
  - transfer = 0; bridge returns to IDLE.
  - rsp_valid[owner] = 1 for exactly one cycle, with rsp_rdata and rsp_err.
  - err_count += rsp_err, saturating at 255.
  - Next state is IDLE.
- Timing with PREADY held high: acceptance edge E0, bridge SETUP after E1, ENABLE after E2, completion sampled at E3, rsp_valid high during the cycle after E3.
- Back-to-back: minimum one IDLE cycle between RESP and the next acceptance. A requester may re-assert req_valid during its own RESP.
- Requesters hold req_valid and command stable until accepted. Dropping req_valid before acceptance is legal; no grant results.
- Hold registers are never X after reset, so the bridge never sees undriven inputs.

Test Plan:
- Single write, requester 0: addr 0x012, data 0xA5, PREADY high -> bridge PADDR 0x012, PWDATA 0xA5, PWRITE 1, PSEL1 = 1; rsp_valid[0] 3 edges after acceptance; rsp_err 0; rsp_rdata 0.
- Read, requester 1: addr 0x140, slave returns 0x3C after 2 wait states -> PSEL2 = 1; rsp_valid[1] with rsp_rdata 0x3C 5 edges after acceptance.
- Both requesters valid every cycle for 6 commands -> grants alternate 0,1,0,1,0,1; no lost or duplicated responses.
- PREADY held low, TIMEOUT = 32 -> transfer drops after 32 XFER cycles; rsp_err 1; err_count increments to 1; bridge reaches IDLE.
- PRESET asserted mid-XFER on a read -> transfer 0 immediately, no rsp_valid; after release, requester 0 wins a simultaneous request.
- Force 260 timeouts -> err_count saturates at 255.
